square_ctl: RTL and testbench

SQUARE_CTL -- requirements
Module: square_ctl

---
 rtl/square_ctl_pkg.sv | 19 +
 rtl/square_ctl_sync_2ff.sv | 22 ++
 rtl/square_ctl.sv | 188 ++++++++++++++++++
 tb/tb_square_ctl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/square_ctl_pkg.sv
// Shared VGA package: default visible-area constants, position widths and
// the movement FSM state type used by the square controller.
package square_ctl_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;

    // Screen coordinates are unsigned 12-bit; the step arithmetic needs one
    // extra bit so that a move past zero shows up as a negative value.
    localparam int POS_W   = 12;
    localparam int ARITH_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2
    } sq_state_t;

endpackage

// File: rtl/square_ctl_sync_2ff.sv
// Two-flop synchronizer for one asynchronous, active-high button input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/square_ctl.sv
// Square position controller: moves a WIDTH x HEIGHT square once per frame
// from synchronized direction buttons, accelerating from 1 px/frame up to
// STEP_MAX px/frame while a direction is held, and clamps it inside the
// visible area.
module square_ctl
    import square_ctl_pkg::*;
#(
    parameter int X_INIT       = 150,
    parameter int Y_INIT       = 100,
    parameter int WIDTH        = 8,
    parameter int HEIGHT       = 8,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int STEP_MAX     = 4,
    parameter int ACCEL_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_home,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             moving
);

    localparam int SPEED_W = $clog2(STEP_MAX + 1);
    localparam int HOLD_W  = $clog2(ACCEL_FRAMES + 1);

    localparam logic signed [ARITH_W-1:0] X_MAX = ARITH_W'(H_ACTIVE - 1 - WIDTH);
    localparam logic signed [ARITH_W-1:0] Y_MAX = ARITH_W'(V_ACTIVE - 1 - HEIGHT);

    localparam logic [SPEED_W-1:0] SPEED_ONE  = SPEED_W'(1);
    localparam logic [SPEED_W-1:0] SPEED_TOP  = SPEED_W'(STEP_MAX);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(ACCEL_FRAMES - 1);

    // Signed per-axis displacement: +spd, -spd, or 0 when neither or both
    // opposing buttons are held.
    function automatic logic signed [ARITH_W-1:0] axis_step(
        input logic               pos,
        input logic               neg,
        input logic [SPEED_W-1:0] spd
    );
        logic signed [ARITH_W-1:0] mag;
        mag = $signed({{(ARITH_W - SPEED_W){1'b0}}, spd});
        if (pos && !neg) begin
            return mag;
        end else if (neg && !pos) begin
            return -mag;
        end else begin
            return '0;
        end
    endfunction

    // Saturate a signed candidate position into [0, hi]; never wraps.
    function automatic logic [POS_W-1:0] clamp_pos(
        input logic signed [ARITH_W-1:0] v,
        input logic signed [ARITH_W-1:0] hi
    );
        if (v < $signed(ARITH_W'(0))) begin
            return '0;
        end else if (v > hi) begin
            return hi[POS_W-1:0];
        end else begin
            return v[POS_W-1:0];
        end
    endfunction

    logic up_s, down_s, left_s, right_s, home_s;

    sync_2ff u_sync_up    (.clk(clk), .rst(rst), .d(btn_up),    .q(up_s));
    sync_2ff u_sync_down  (.clk(clk), .rst(rst), .d(btn_down),  .q(down_s));
    sync_2ff u_sync_left  (.clk(clk), .rst(rst), .d(btn_left),  .q(left_s));
    sync_2ff u_sync_right (.clk(clk), .rst(rst), .d(btn_right), .q(right_s));
    sync_2ff u_sync_home  (.clk(clk), .rst(rst), .d(btn_home),  .q(home_s));

    logic vblnk_d;
    logic tick;

    // Delayed copy of vblnk for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_d <= 1'b0;
        end else begin
            vblnk_d <= vblnk;
        end
    end

    assign tick = vblnk & ~vblnk_d;

    sq_state_t                 state;
    logic [SPEED_W-1:0]        speed;
    logic [HOLD_W-1:0]         hold_cnt;

    logic signed [ARITH_W-1:0] dx_step, dy_step;
    logic signed [ARITH_W-1:0] x_sum, y_sum;
    logic [POS_W-1:0]          x_next, y_next;
    logic                      any_dir;

    // Candidate clamped position using the speed held before this tick.
    always_comb begin
        dx_step = axis_step(right_s, left_s, speed);
        dy_step = axis_step(down_s, up_s, speed);
        x_sum   = $signed({1'b0, xpos}) + dx_step;
        y_sum   = $signed({1'b0, ypos}) + dy_step;
        x_next  = clamp_pos(x_sum, X_MAX);
        y_next  = clamp_pos(y_sum, Y_MAX);
        any_dir = (right_s ^ left_s) | (down_s ^ up_s);
    end

    // Movement FSM; position, speed and state only advance on a frame tick.
    // hold_cnt counts frames already moved at the current speed, so the
    // entry tick out of IDLE is the first of the ACCEL_FRAMES at speed 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            speed    <= SPEED_ONE;
            hold_cnt <= '0;
            xpos     <= POS_W'(X_INIT);
            ypos     <= POS_W'(Y_INIT);
            moving   <= 1'b0;
        end else if (tick) begin
            if (home_s) begin
                state    <= ST_IDLE;
                speed    <= SPEED_ONE;
                hold_cnt <= '0;
                xpos     <= POS_W'(X_INIT);
                ypos     <= POS_W'(Y_INIT);
                moving   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (any_dir) begin
                            state    <= ST_ACCEL;
                            speed    <= SPEED_ONE;
                            hold_cnt <= HOLD_W'(1);
                            xpos     <= x_next;
                            ypos     <= y_next;
                            moving   <= 1'b1;
                        end
                    end
                    ST_ACCEL: begin
                        if (!any_dir) begin
                            state    <= ST_IDLE;
                            speed    <= SPEED_ONE;
                            hold_cnt <= '0;
                            moving   <= 1'b0;
                        end else begin
                            xpos <= x_next;
                            ypos <= y_next;
                            if (hold_cnt == HOLD_LAST) begin
                                hold_cnt <= '0;
                                speed    <= speed + SPEED_ONE;
                                if ((speed + SPEED_ONE) == SPEED_TOP) begin
                                    state <= ST_CRUISE;
                                end
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                    end
                    ST_CRUISE: begin
                        if (!any_dir) begin
                            state    <= ST_IDLE;
                            speed    <= SPEED_ONE;
                            hold_cnt <= '0;
                            moving   <= 1'b0;
                        end else begin
                            speed <= SPEED_TOP;
                            xpos  <= x_next;
                            ypos  <= y_next;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        speed    <= SPEED_ONE;
                        hold_cnt <= '0;
                        moving   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_square_ctl.sv
// Directed bench for square_ctl with a per-frame expected-state scoreboard.
module tb_square_ctl;

    logic        clk;
    logic        rst;
    logic        vblnk;
    logic        btn_up, btn_down, btn_left, btn_right, btn_home;
    logic [11:0] xpos, ypos;
    logic        moving;

    int total;
    int bad;

    typedef struct {
        int x;
        int y;
        bit mov;
    } exp_t;

    exp_t sb[$];

    // Reference state of the square
    int mx, my, mheld;
    bit mmov;

    square_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .vblnk    (vblnk),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_home (btn_home),
        .xpos     (xpos),
        .ypos     (ypos),
        .moving   (moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // One frame of the reference: speed is 1 for the first 8 held frames,
    // then 2, then 3, then 4 from the 25th held frame onward.
    task automatic model_tick(input bit u, input bit d, input bit l, input bit r, input bit h);
        int dx, dy, spd;
        exp_t e;
        dx = int'(r) - int'(l);
        dy = int'(d) - int'(u);
        if (h) begin
            mx = 150; my = 100; mheld = 0; mmov = 1'b0;
        end else if (dx == 0 && dy == 0) begin
            mheld = 0; mmov = 1'b0;
        end else begin
            spd = 1 + mheld / 8;
            if (spd > 4) spd = 4;
            mx = clampi(mx + dx * spd, 791);
            my = clampi(my + dy * spd, 591);
            mheld++;
            mmov = 1'b1;
        end
        e.x = mx; e.y = my; e.mov = mmov;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        mx = 150; my = 100; mheld = 0; mmov = 1'b0;
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        @(negedge clk);
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s scoreboard empty got=%0d expected=%0d", tag, sb.size(), 1);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val({tag, "_x"}, int'(xpos), e.x);
            check_val({tag, "_y"}, int'(ypos), e.y);
            check_val({tag, "_mov"}, int'(moving), int'(e.mov));
        end
    endtask

    // Set buttons, let them synchronize, then issue one vblnk pulse.
    task automatic frame(input bit u, input bit d, input bit l, input bit r, input bit h,
                         input string tag);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_home = h;
        model_tick(u, d, l, r, h);
        repeat (4) @(posedge clk);
        #1 vblnk = 1'b1;
        repeat (3) @(posedge clk);
        #1 vblnk = 1'b0;
        check_pop(tag);
    endtask

    initial begin
        exp_t e;
        total = 0;
        bad   = 0;
        rst = 1'b1; vblnk = 1'b0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_home = 0;
        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("rst_x", int'(xpos), 150);
        check_val("rst_y", int'(ypos), 100);
        check_val("rst_mov", int'(moving), 0);
        rst = 1'b0;

        // Idle frames
        for (int i = 0; i < 3; i++) frame(0, 0, 0, 0, 0, "idle");

        // Right held 20 frames: 8 @1, 8 @2, 4 @3
        for (int i = 0; i < 20; i++) frame(0, 0, 0, 1, 0, "right_accel");
        check_val("right20_x", int'(xpos), 186);
        // Keep going into cruise
        for (int i = 0; i < 6; i++) frame(0, 0, 0, 1, 0, "right_cruise");

        // Home during cruise with right still held
        frame(0, 0, 0, 1, 1, "home");
        check_val("home_x", int'(xpos), 150);
        check_val("home_mov", int'(moving), 0);
        frame(0, 0, 0, 0, 0, "post_home");

        // Opposing horizontal buttons plus down
        for (int i = 0; i < 5; i++) frame(0, 1, 1, 1, 0, "lr_down");
        check_val("lr_down_x", int'(xpos), 150);
        check_val("lr_down_y", int'(ypos), 105);
        frame(0, 0, 0, 0, 0, "release1");

        // Left streak down to x=2 in cruise, then clamp at 0
        for (int i = 0; i < 49; i++) frame(0, 0, 1, 0, 0, "left_run");
        check_val("left_x2", int'(xpos), 2);
        frame(0, 0, 1, 0, 0, "left_clamp");
        check_val("left_zero", int'(xpos), 0);
        frame(0, 0, 1, 0, 0, "left_hold0");
        check_val("left_nowrap", int'(xpos), 0);
        frame(0, 0, 0, 0, 0, "release2");

        // Right streak up to the right limit
        for (int i = 0; i < 215; i++) frame(0, 0, 0, 1, 0, "right_run");
        check_val("right_lim", int'(xpos), 791);
        frame(0, 0, 0, 1, 0, "right_hold");
        check_val("right_lim_hold", int'(xpos), 791);
        frame(0, 0, 0, 0, 0, "release3");

        // vblnk held high for 100 cycles: one update only
        btn_left = 1'b1;
        model_tick(0, 0, 1, 0, 0);
        repeat (4) @(posedge clk);
        #1 vblnk = 1'b1;
        repeat (100) @(posedge clk);
        check_pop("vblnk_long");
        e.x = mx; e.y = my; e.mov = mmov;
        sb.push_back(e);
        #1 vblnk = 1'b0;
        repeat (5) @(posedge clk);
        check_pop("vblnk_after");
        check_val("vblnk_one_x", int'(xpos), 790);

        // Asynchronous reset mid-move
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_val("arst_x", int'(xpos), 150);
        check_val("arst_y", int'(ypos), 100);
        check_val("arst_mov", int'(moving), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        frame(0, 0, 0, 1, 0, "post_rst");
        check_val("post_rst_x", int'(xpos), 151);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
